// File: rtl/cam_entry_alloc.sv
// cam_entry_alloc: write-side controller for a static-config CAM.
// Keeps a circular free list of entry indices, hands out up to NUM_WR_PORTS
// entries per cycle (all-or-nothing), drives the CAM write ports one cycle
// later, accepts releases and exports the per-entry valid vector.
module cam_entry_alloc #(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned INDEX          = 5,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned NUM_WR_PORTS   = 2,
    parameter int unsigned NUM_FREE_PORTS = 2
) (
    input  logic                              clkGated,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic [NUM_WR_PORTS-1:0]           allocReq_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]     allocTag_i,
    output logic                              allocGrant_o,
    output logic [NUM_WR_PORTS*INDEX-1:0]     allocIdx_o,
    input  logic [NUM_FREE_PORTS-1:0]         freeEn_i,
    input  logic [NUM_FREE_PORTS*INDEX-1:0]   freeIdx_i,
    output logic [NUM_WR_PORTS-1:0]           camWrEn_o,
    output logic [NUM_WR_PORTS*INDEX-1:0]     camAddrWr_o,
    output logic [NUM_WR_PORTS*WIDTH-1:0]     camDataWr_o,
    output logic [DEPTH-1:0]                  validVect_o,
    output logic [INDEX:0]                    freeCnt_o,
    output logic                              ready_o,
    output logic                              freeErr_o
);

    localparam int unsigned CNT_W = INDEX + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            w_run;
    logic                            w_reload;

    logic [INDEX-1:0]                r_free_list [DEPTH];
    logic [INDEX-1:0]                r_head;
    logic [INDEX-1:0]                r_tail;
    logic [CNT_W-1:0]                r_free_cnt;
    logic [DEPTH-1:0]                r_valid;

    logic [NUM_WR_PORTS-1:0]         r_cam_wr_en;
    logic [NUM_WR_PORTS*INDEX-1:0]   r_cam_addr;
    logic [NUM_WR_PORTS*WIDTH-1:0]   r_cam_data;
    logic                            r_ready;
    logic                            r_free_err;

    logic [CNT_W-1:0]                w_req_cnt;
    logic [INDEX-1:0]                w_rd_ptr;
    logic [NUM_WR_PORTS*INDEX-1:0]   w_alloc_idx;
    logic                            w_grant;

    logic [CNT_W-1:0]                w_rel_cnt;
    logic [NUM_FREE_PORTS-1:0]       w_rel_acc;
    logic [INDEX-1:0]                w_wr_ptr [NUM_FREE_PORTS];
    logic                            w_dup;
    logic                            w_free_err;
    logic [DEPTH-1:0]                w_valid_nxt;

    // Next-state decode; flush request or FLUSH state rebuilds the list
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            RUN: begin
                if (flush_i) begin
                    w_state_nxt = FLUSH;
                    w_reload    = 1'b1;
                end else begin
                    w_run = 1'b1;
                end
            end
            FLUSH: begin
                w_state_nxt = RUN;
                w_reload    = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clkGated) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Allocation: requesting lanes take consecutive list slots from head
    always_comb begin
        w_req_cnt   = '0;
        w_rd_ptr    = '0;
        w_alloc_idx = '0;
        for (int l = 0; l < NUM_WR_PORTS; l++) begin
            if (allocReq_i[l]) begin
                w_rd_ptr                     = r_head + INDEX'(w_req_cnt);
                w_alloc_idx[l*INDEX +: INDEX] = r_free_list[w_rd_ptr];
                w_req_cnt                    = w_req_cnt + CNT_W'(1);
            end
        end
        w_grant = w_run && (w_req_cnt != '0) && (w_req_cnt <= r_free_cnt);
    end

    // Release: accept valid, non-duplicate indices and assign tail slots
    always_comb begin
        w_rel_cnt  = '0;
        w_rel_acc  = '0;
        w_dup      = 1'b0;
        w_free_err = 1'b0;
        for (int j = 0; j < NUM_FREE_PORTS; j++) begin
            w_wr_ptr[j] = r_tail + INDEX'(w_rel_cnt);
            w_dup       = 1'b0;
            for (int k = 0; k < j; k++) begin
                if (freeEn_i[k] && (freeIdx_i[k*INDEX +: INDEX] == freeIdx_i[j*INDEX +: INDEX])) begin
                    w_dup = 1'b1;
                end
            end
            if (w_run && freeEn_i[j]) begin
                if (r_valid[freeIdx_i[j*INDEX +: INDEX]] && !w_dup) begin
                    w_rel_acc[j] = 1'b1;
                    w_rel_cnt    = w_rel_cnt + CNT_W'(1);
                end else begin
                    w_free_err = 1'b1;
                end
            end
        end
    end

    // Valid vector update: set granted entries, clear released ones
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_grant) begin
            for (int l = 0; l < NUM_WR_PORTS; l++) begin
                if (allocReq_i[l]) begin
                    w_valid_nxt[w_alloc_idx[l*INDEX +: INDEX]] = 1'b1;
                end
            end
        end
        for (int j = 0; j < NUM_FREE_PORTS; j++) begin
            if (w_rel_acc[j]) begin
                w_valid_nxt[freeIdx_i[j*INDEX +: INDEX]] = 1'b0;
            end
        end
    end

    // Free list, pointers, count and valid vector
    always_ff @(posedge clkGated) begin
        if (reset || w_reload) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_free_list[k] <= INDEX'(k);
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_free_cnt <= CNT_W'(DEPTH);
            r_valid    <= '0;
        end else begin
            for (int j = 0; j < NUM_FREE_PORTS; j++) begin
                if (w_rel_acc[j]) begin
                    r_free_list[w_wr_ptr[j]] <= freeIdx_i[j*INDEX +: INDEX];
                end
            end
            if (w_grant) begin
                r_head <= r_head + INDEX'(w_req_cnt);
            end
            r_tail     <= r_tail + INDEX'(w_rel_cnt);
            r_free_cnt <= r_free_cnt - (w_grant ? w_req_cnt : CNT_W'(0)) + w_rel_cnt;
            r_valid    <= w_valid_nxt;
        end
    end

    // Registered CAM write port, ready and release-error pulse
    always_ff @(posedge clkGated) begin
        if (reset) begin
            r_cam_wr_en <= '0;
            r_cam_addr  <= '0;
            r_cam_data  <= '0;
            r_ready     <= 1'b0;
            r_free_err  <= 1'b0;
        end else begin
            r_cam_wr_en <= w_grant ? allocReq_i : '0;
            if (w_grant) begin
                r_cam_addr <= w_alloc_idx;
                r_cam_data <= allocTag_i;
            end
            r_ready    <= (w_state_nxt == RUN);
            r_free_err <= w_free_err;
        end
    end

    assign allocGrant_o = w_grant;
    assign allocIdx_o   = w_alloc_idx;
    assign camWrEn_o    = r_cam_wr_en;
    assign camAddrWr_o  = r_cam_addr;
    assign camDataWr_o  = r_cam_data;
    assign validVect_o  = r_valid;
    assign freeCnt_o    = r_free_cnt;
    assign ready_o      = r_ready;
    assign freeErr_o    = r_free_err;

endmodule

// File: tb/tb_cam_entry_alloc.sv
// Bench for cam_entry_alloc: directed steps followed by random traffic,
// checked against a queue-based free-list model.
module tb_cam_entry_alloc;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned INDEX = 5;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NWR   = 2;
    localparam int unsigned NFR   = 2;

    logic                  clkGated = 1'b0;
    logic                  reset;
    logic                  flush_i;
    logic [NWR-1:0]        allocReq_i;
    logic [NWR*WIDTH-1:0]  allocTag_i;
    logic                  allocGrant_o;
    logic [NWR*INDEX-1:0]  allocIdx_o;
    logic [NFR-1:0]        freeEn_i;
    logic [NFR*INDEX-1:0]  freeIdx_i;
    logic [NWR-1:0]        camWrEn_o;
    logic [NWR*INDEX-1:0]  camAddrWr_o;
    logic [NWR*WIDTH-1:0]  camDataWr_o;
    logic [DEPTH-1:0]      validVect_o;
    logic [INDEX:0]        freeCnt_o;
    logic                  ready_o;
    logic                  freeErr_o;

    cam_entry_alloc #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
        .NUM_WR_PORTS(NWR), .NUM_FREE_PORTS(NFR)
    ) dut (
        .clkGated(clkGated), .reset(reset), .flush_i(flush_i),
        .allocReq_i(allocReq_i), .allocTag_i(allocTag_i),
        .allocGrant_o(allocGrant_o), .allocIdx_o(allocIdx_o),
        .freeEn_i(freeEn_i), .freeIdx_i(freeIdx_i),
        .camWrEn_o(camWrEn_o), .camAddrWr_o(camAddrWr_o), .camDataWr_o(camDataWr_o),
        .validVect_o(validVect_o), .freeCnt_o(freeCnt_o),
        .ready_o(ready_o), .freeErr_o(freeErr_o)
    );

    always #5 clkGated = ~clkGated;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of free indices plus an allocated bitmap
    int                   q[$];
    logic [DEPTH-1:0]     mv;
    bit                   m_flushing;
    logic [NWR-1:0]       e_wr;
    logic [NWR*INDEX-1:0] e_addr;
    logic [NWR*WIDTH-1:0] e_data;
    bit                   e_err;
    bit                   e_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reload();
        q.delete();
        for (int k = 0; k < DEPTH; k++) q.push_back(k);
        mv = '0;
    endtask

    task automatic drive(input logic [1:0] req, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [1:0] fen, input logic [4:0] f0, input logic [4:0] f1,
                         input logic fl);
        allocReq_i = req;
        allocTag_i = {t1, t0};
        freeEn_i   = fen;
        freeIdx_i  = {f1, f0};
        flush_i    = fl;
    endtask

    task automatic model_step(input bit g);
        logic [DEPTH-1:0] old;
        bit dup;
        bit nf;
        int idx;
        e_err = 1'b0;
        e_wr  = '0;
        nf    = !m_flushing && flush_i;
        if (m_flushing || flush_i) begin
            model_reload();
        end else begin
            old = mv;
            if (g) begin
                e_wr = allocReq_i;
                for (int l = 0; l < NWR; l++) begin
                    if (allocReq_i[l]) begin
                        idx = q.pop_front();
                        e_addr[l*INDEX +: INDEX] = INDEX'(idx);
                        e_data[l*WIDTH +: WIDTH] = allocTag_i[l*WIDTH +: WIDTH];
                        mv[idx] = 1'b1;
                    end
                end
            end
            for (int j = 0; j < NFR; j++) begin
                if (freeEn_i[j]) begin
                    idx = int'(freeIdx_i[j*INDEX +: INDEX]);
                    dup = 1'b0;
                    for (int k = 0; k < j; k++)
                        if (freeEn_i[k] && int'(freeIdx_i[k*INDEX +: INDEX]) == idx) dup = 1'b1;
                    if (old[idx] && !dup) begin
                        q.push_back(idx);
                        mv[idx] = 1'b0;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            end
        end
        m_flushing = nf;
        e_ready    = !nf;
    endtask

    // One clock: check combinational grant, advance model, check registered state
    task automatic cycle();
        int n;
        int pos;
        bit g;
        logic [NWR*INDEX-1:0] ei;
        #1;
        n = $countones(allocReq_i);
        g = !m_flushing && !flush_i && n > 0 && n <= q.size();
        check("grant", 64'(allocGrant_o), 64'(g));
        if (g) begin
            ei  = '0;
            pos = 0;
            for (int l = 0; l < NWR; l++) begin
                if (allocReq_i[l]) begin
                    ei[l*INDEX +: INDEX] = INDEX'(q[pos]);
                    pos++;
                end
            end
            check("alloc_idx", 64'(allocIdx_o), 64'(ei));
        end
        @(posedge clkGated);
        model_step(g);
        #1;
        check("cam_wr_en", 64'(camWrEn_o), 64'(e_wr));
        for (int l = 0; l < NWR; l++) begin
            if (e_wr[l]) begin
                check("cam_addr", 64'(camAddrWr_o[l*INDEX +: INDEX]), 64'(e_addr[l*INDEX +: INDEX]));
                check("cam_data", 64'(camDataWr_o[l*WIDTH +: WIDTH]), 64'(e_data[l*WIDTH +: WIDTH]));
            end
        end
        check("valid_vect", 64'(validVect_o), 64'(mv));
        check("free_cnt", 64'(freeCnt_o), 64'(q.size()));
        check("ready", 64'(ready_o), 64'(e_ready));
        check("free_err", 64'(freeErr_o), 64'(e_err));
    endtask

    initial begin
        int vl[$];
        logic [4:0] fi0;
        logic [4:0] fi1;

        reset = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clkGated);
        #1;
        check("rst_ready", 64'(ready_o), 64'(0));
        check("rst_cnt", 64'(freeCnt_o), 64'(DEPTH));
        check("rst_valid", 64'(validVect_o), 64'(0));
        check("rst_wr_en", 64'(camWrEn_o), 64'(0));
        check("rst_addr", 64'(camAddrWr_o), 64'(0));
        check("rst_data", 64'(camDataWr_o), 64'(0));
        check("rst_err", 64'(freeErr_o), 64'(0));

        reset = 1'b0;
        model_reload();
        m_flushing = 1'b0;
        e_addr = '0;
        e_data = '0;
        cycle();

        // Two-lane allocation from a fresh list
        drive(2'b11, 8'hA1, 8'hB2, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        check("plan_addr", 64'(camAddrWr_o), 64'(10'h020));
        check("plan_data", 64'(camDataWr_o), 64'(16'hB2A1));
        check("plan_cnt", 64'(freeCnt_o), 64'(30));

        // Single upper lane
        drive(2'b10, 8'h00, 8'h5C, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();

        // Fill down to one entry, then all-or-nothing at count 1 and 0
        for (int i = 0; i < 14; i++) begin
            drive(2'b11, 8'(i), 8'(i + 100), 2'b00, 5'd0, 5'd0, 1'b0);
            cycle();
        end
        drive(2'b11, 8'h11, 8'h22, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        drive(2'b01, 8'h33, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        drive(2'b11, 8'h44, 8'h55, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        check("full_cnt", 64'(freeCnt_o), 64'(0));

        // Duplicate release, then a legal and an illegal release
        drive(2'b00, 8'h00, 8'h00, 2'b11, 5'd5, 5'd5, 1'b0);
        cycle();
        check("dup_err", 64'(freeErr_o), 64'(1));
        drive(2'b00, 8'h00, 8'h00, 2'b01, 5'd7, 5'd0, 1'b0);
        cycle();
        drive(2'b00, 8'h00, 8'h00, 2'b01, 5'd7, 5'd0, 1'b0);
        cycle();
        drive(2'b11, 8'h66, 8'h77, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();

        // Release at count 0 is not allocatable in the same cycle
        drive(2'b01, 8'h88, 8'h00, 2'b01, 5'd3, 5'd0, 1'b0);
        cycle();
        drive(2'b01, 8'h99, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        check("wrap_addr", 64'(camAddrWr_o[INDEX-1:0]), 64'(3));

        // Flush with a pending allocation, then allocate from the rebuilt list
        drive(2'b00, 8'h00, 8'h00, 2'b11, 5'd10, 5'd11, 1'b0);
        cycle();
        drive(2'b00, 8'h00, 8'h00, 2'b11, 5'd20, 5'd21, 1'b0);
        cycle();
        drive(2'b11, 8'hAA, 8'hBB, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        drive(2'b11, 8'hCC, 8'hDD, 2'b00, 5'd0, 5'd0, 1'b1);
        cycle();
        drive(2'b00, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        drive(2'b01, 8'hEE, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle();
        check("flush_addr", 64'(camAddrWr_o[INDEX-1:0]), 64'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            vl.delete();
            for (int k = 0; k < DEPTH; k++) if (mv[k]) vl.push_back(k);
            fi0 = 5'($urandom_range(0, DEPTH - 1));
            fi1 = 5'($urandom_range(0, DEPTH - 1));
            if (vl.size() > 0 && $urandom_range(0, 3) != 0) fi0 = 5'(vl[$urandom_range(0, vl.size() - 1)]);
            if (vl.size() > 0 && $urandom_range(0, 3) != 0) fi1 = 5'(vl[$urandom_range(0, vl.size() - 1)]);
            drive(2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), fi0, fi1,
                  1'($urandom_range(0, 49) == 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
